fwd_scoreboard: RTL and testbench
=================================

# fwd_scoreboard

Parametrised hazard and forwarding unit for the in-order MIPS32 pipeline. It replaces the fixed three-source (E/M/W) comparator with a shift-register scoreboard of in-flight producers, `DEPTH` slots deep. Each cycle it:
- tracks destination register, write-enable and result-availability stage per slot;
- selects the youngest valid forwarding source for the decode-stage operands;
- raises `stall` on load-use (or any not-yet-available) hazards;
- inserts bubbles and honours branch flushes;
- keeps stall and flush statistics counters.

## Interface
Parameters:
- `XLEN`, 32, datapath width.
- `RADDR`, 5, register address width.
- `DEPTH`, 3, number of post-decode producer slots (slot 0 = E, 1 = M, 2 = W).
- `LOAD_AVAIL`, 1, first slot index at which a load result is valid in `slot_data`.
- `FLUSH_DEPTH`, 1, number of youngest slots (0..FLUSH_DEPTH-1) invalidated by `flush`.

Ports (reset `rst`, synchronous, active-high; clock `clk`):
- `clk`  in  1  clock.
- `rst`  in  1  synchronous active-high reset.
- `issue_valid`  in  1  decode holds a valid instruction.
- `issue_we`  in  1  that instruction writes a register.
- `issue_rd`  in  RADDR  its destination register.
- `issue_load`  in  1  its result comes from memory.
- `rs_addr`, `rt_addr`  in  RADDR  decode source registers.
- `rs_used`, `rt_used`  in  1  source actually read by the instruction.
- `slot_data`  in  DEPTH*XLEN  result value held by each slot; slot i occupies bits [i*XLEN +: XLEN].
- `flush`  in  1  taken branch resolved; kill younger work.
- `stall`  out  1  hold PC and decode this cycle.
- `fwd_a_en`, `fwd_b_en`  out  1  override rs/rt register-file value.
- `fwd_a`, `fwd_b`  out  XLEN  forwarded values.
- `stall_count`  out  32  cycles with `stall`=1, saturating.
- `flush_count`  out  32  cycles with `flush`=1, saturating.

## Operation
**Slot state.** Each slot holds `v`, `we`, `rd` and `avail`:
- `avail` = `LOAD_AVAIL` for loads, 0 otherwise.

**Operand match (per operand, rs and rt alike).**
- A slot matches when `v & we & rd==addr & addr!=0 & used`.
- The youngest (lowest-index) matching slot wins.

**Forward or hazard.** For the winning slot i:
- If i >= `avail`: `fwd_x_en`=1 and `fwd_x`=`slot_data[i]`.
- Otherwise: hazard; `fwd_x_en`=0.
- No match: `fwd_x_en`=0 and `fwd_x`=0.

**Stall.** `stall` = (hazard on rs | hazard on rt) & `issue_valid` & ~`flush`.

**Shift at each posedge.**
- slot[i+1] <= slot[i] for i < DEPTH-1; slot DEPTH-1 retires.
- slot[0] <= issue entry if `issue_valid` & ~`stall` & ~`flush`; otherwise a bubble (v=0).
- On `flush`, slots 1..FLUSH_DEPTH-1 load as bubbles instead of shifting; older slots shift normally.

**Register-file ordering.** The register file writes before it reads, so a producer retired from slot DEPTH-1 is visible through the normal read path.

**Register 0.** Never forwarded and never causes a stall.

**Counters.** Each increments by 1 in a cycle where its condition holds and saturates at 32'hFFFF_FFFF.

## Timing
- **Reset.** All slots invalid; `stall`=0, `fwd_*_en`=0, `fwd_*`=0, both counters 0. `rst` mid-operation clears everything at the next edge.
- **Output timing.** All outputs except the counters are combinational from registered slot state plus current inputs. Counters are registered: a stall in cycle n is visible in `stall_count` in cycle n+1.
- **Stall length.** A consumer directly behind a producer with `avail`=k stalls exactly k cycles. With the default `LOAD_AVAIL`=1, a load-use stalls 1 cycle. An ALU producer never stalls.
- **Simultaneous events.**
  - `flush` and hazard in the same cycle: `flush` wins, `stall`=0, no issue.
  - `rst` and `flush` in the same cycle: `rst` wins, `flush_count` stays 0.
- **Bubbles.** A stall cycle inserts exactly one bubble into slot 0 while older slots continue draining, so the hazard clears without a deadlock.

## Test plan
1. **ALU forward.** Issue we=1, rd=3. Next cycle rs_addr=3, rs_used=1, slot_data[0]=0x1234 -> `fwd_a_en`=1, `fwd_a`=0x1234, `stall`=0.
2. **Load-use stall.** Issue load rd=4. Next cycle rt_addr=4, rt_used=1 -> `stall`=1 for one cycle and slot 0 becomes a bubble. Following cycle: `fwd_b`=slot_data[1], `stall`=0, `stall_count`=1.
3. **Youngest priority.** rd=5 producers in slot 0 (0xAAAA) and slot 2 (0xBBBB), rs_addr=5 -> `fwd_a`=0xAAAA.
4. **r0 and unused sources.** Producer rd=0 with rs_addr=0 -> `fwd_a_en`=0. Load rd=6 in slot 0 with rt_addr=6 but rt_used=0 -> `stall`=0.
5. **Flush over hazard.** Load rd=7 in slot 0, consumer rs_addr=7, `flush`=1 -> `stall`=0. Next cycle slot 0 is invalid, `flush_count`=1, and rs_addr=7 gives `fwd_a_en`=1 from slot 1.
6. **Reset mid-stream.** Fill all slots, assert `rst` for one cycle -> every matching query returns `fwd_*_en`=0, `stall`=0, counters 0.

Source files
------------

// File: rtl/fwd_scoreboard.sv
// Scoreboard-based hazard and forwarding unit for the in-order MIPS32 pipeline.
// Tracks DEPTH in-flight producers and picks the youngest forwarding source.
module fwd_scoreboard #(
  parameter int XLEN        = 32,
  parameter int RADDR       = 5,
  parameter int DEPTH       = 3,
  parameter int LOAD_AVAIL  = 1,
  parameter int FLUSH_DEPTH = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issue_valid,
  input  logic                  issue_we,
  input  logic [RADDR-1:0]      issue_rd,
  input  logic                  issue_load,
  input  logic [RADDR-1:0]      rs_addr,
  input  logic [RADDR-1:0]      rt_addr,
  input  logic                  rs_used,
  input  logic                  rt_used,
  input  logic [DEPTH*XLEN-1:0] slot_data,
  input  logic                  flush,
  output logic                  stall,
  output logic                  fwd_a_en,
  output logic                  fwd_b_en,
  output logic [XLEN-1:0]       fwd_a,
  output logic [XLEN-1:0]       fwd_b,
  output logic [31:0]           stall_count,
  output logic [31:0]           flush_count
);

  logic [DEPTH-1:0]       v_q, v_d;
  logic [DEPTH-1:0]       we_q, we_d;
  logic [DEPTH-1:0]       ld_q, ld_d;
  logic [DEPTH*RADDR-1:0] rd_q, rd_d;
  logic [31:0]            stall_count_q, stall_count_d;
  logic [31:0]            flush_count_q, flush_count_d;
  logic                   haz_a, haz_b;

  // Returns {hazard, forward_enable, forward_value} for one operand.
  function automatic logic [XLEN+1:0] resolve(
    input logic [RADDR-1:0]      a,
    input logic                  u,
    input logic [DEPTH-1:0]      v,
    input logic [DEPTH-1:0]      we,
    input logic [DEPTH-1:0]      ld,
    input logic [DEPTH*RADDR-1:0] rd,
    input logic [DEPTH*XLEN-1:0] data
  );
    logic hit;
    hit = 1'b0;
    resolve = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!hit && u && a != '0 && v[i] && we[i]
          && rd[i*RADDR +: RADDR] == a) begin
        hit = 1'b1;
        if (ld[i] && i < LOAD_AVAIL) resolve[XLEN+1] = 1'b1;
        else resolve = {2'b01, data[i*XLEN +: XLEN]};
      end
    end
  endfunction

  always_comb begin
    {haz_a, fwd_a_en, fwd_a} = resolve(rs_addr, rs_used, v_q, we_q,
                                       ld_q, rd_q, slot_data);
    {haz_b, fwd_b_en, fwd_b} = resolve(rt_addr, rt_used, v_q, we_q,
                                       ld_q, rd_q, slot_data);
    stall = (haz_a | haz_b) & issue_valid & ~flush;
  end

  always_comb begin
    v_d  = '0;
    we_d = '0;
    ld_d = '0;
    rd_d = '0;
    v_d[0]           = issue_valid & ~stall & ~flush;
    we_d[0]          = issue_we;
    ld_d[0]          = issue_load;
    rd_d[RADDR-1:0]  = issue_rd;
    // Flush kills the youngest FLUSH_DEPTH slots; older work keeps draining.
    for (int i = 1; i < DEPTH; i++) begin
      v_d[i]                 = v_q[i-1] & ~(flush && i < FLUSH_DEPTH);
      we_d[i]                = we_q[i-1];
      ld_d[i]                = ld_q[i-1];
      rd_d[i*RADDR +: RADDR] = rd_q[(i-1)*RADDR +: RADDR];
    end
    stall_count_d = stall_count_q;
    flush_count_d = flush_count_q;
    if (stall && stall_count_q != '1) stall_count_d = stall_count_q + 32'd1;
    if (flush && flush_count_q != '1) flush_count_d = flush_count_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q           <= '0;
      we_q          <= '0;
      ld_q          <= '0;
      rd_q          <= '0;
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      v_q           <= v_d;
      we_q          <= we_d;
      ld_q          <= ld_d;
      rd_q          <= rd_d;
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign stall_count = stall_count_q;
  assign flush_count = flush_count_q;

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed and randomized checks of fwd_scoreboard against a
// producer-list reference model.
module tb_fwd_scoreboard;
  localparam int XLEN = 32;
  localparam int RADDR = 5;
  localparam int DEPTH = 3;
  localparam int LOAD_AVAIL = 1;
  localparam int FLUSH_DEPTH = 1;

  logic clk = 1'b0;
  logic rst, issue_valid, issue_we, issue_load;
  logic [RADDR-1:0] issue_rd, rs_addr, rt_addr;
  logic rs_used, rt_used, flush;
  logic [DEPTH*XLEN-1:0] slot_data;
  logic stall, fwd_a_en, fwd_b_en;
  logic [XLEN-1:0] fwd_a, fwd_b;
  logic [31:0] stall_count, flush_count;

  int total = 0;
  int passed = 0;
  int failed = 0;

  typedef struct packed {
    logic v;
    logic we;
    logic ld;
    logic [RADDR-1:0] rd;
  } ent_t;

  // m[k] is the producer issued k+1 cycles ago (k = its age in slots).
  ent_t m [DEPTH];
  logic [31:0] m_sc, m_fc;

  fwd_scoreboard #(
    .XLEN(XLEN), .RADDR(RADDR), .DEPTH(DEPTH),
    .LOAD_AVAIL(LOAD_AVAIL), .FLUSH_DEPTH(FLUSH_DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_we(issue_we),
    .issue_rd(issue_rd), .issue_load(issue_load),
    .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_used(rs_used), .rt_used(rt_used),
    .slot_data(slot_data), .flush(flush),
    .stall(stall), .fwd_a_en(fwd_a_en), .fwd_b_en(fwd_b_en),
    .fwd_a(fwd_a), .fwd_b(fwd_b),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  function automatic logic [DEPTH*XLEN-1:0] pack(
    input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2);
    pack = {d2, d1, d0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // A producer of age k is ready once k reaches its result latency.
  task automatic ref_op(input logic [RADDR-1:0] a, input logic u,
                        output logic en, output logic haz,
                        output logic [31:0] val);
    en = 1'b0;
    haz = 1'b0;
    val = '0;
    if (u && a != 0) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (m[k].v && m[k].we && m[k].rd == a) begin
          if (k < (m[k].ld ? LOAD_AVAIL : 0)) haz = 1'b1;
          else begin
            en = 1'b1;
            val = slot_data[k*XLEN +: XLEN];
          end
          break;
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    logic ea, ha, eb, hb;
    logic [31:0] va, vb;
    ref_op(rs_addr, rs_used, ea, ha, va);
    ref_op(rt_addr, rt_used, eb, hb, vb);
    chk({tag, "_stall"}, stall, (ha | hb) & issue_valid & ~flush);
    chk({tag, "_a_en"}, fwd_a_en, ea);
    chk({tag, "_a"}, fwd_a, va);
    chk({tag, "_b_en"}, fwd_b_en, eb);
    chk({tag, "_b"}, fwd_b, vb);
    chk({tag, "_sc"}, stall_count, m_sc);
    chk({tag, "_fc"}, flush_count, m_fc);
  endtask

  task automatic cycle();
    logic ea, ha, eb, hb, st;
    logic [31:0] va, vb;
    ref_op(rs_addr, rs_used, ea, ha, va);
    ref_op(rt_addr, rt_used, eb, hb, vb);
    st = (ha | hb) & issue_valid & ~flush;
    @(posedge clk);
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) m[k] = '0;
      m_sc = 0;
      m_fc = 0;
    end else begin
      if (st && m_sc != 32'hFFFF_FFFF) m_sc = m_sc + 1;
      if (flush && m_fc != 32'hFFFF_FFFF) m_fc = m_fc + 1;
      for (int k = DEPTH - 1; k >= 1; k--)
        m[k] = (flush && k < FLUSH_DEPTH) ? '0 : m[k-1];
      if (issue_valid && !st && !flush)
        m[0] = '{v: 1'b1, we: issue_we, ld: issue_load, rd: issue_rd};
      else
        m[0] = '0;
    end
    #1;
  endtask

  task automatic step(input string tag);
    check_all(tag);
    cycle();
  endtask

  task automatic idle();
    rst = 1'b0;
    issue_valid = 1'b0;
    issue_we = 1'b0;
    issue_load = 1'b0;
    issue_rd = '0;
    rs_addr = '0;
    rt_addr = '0;
    rs_used = 1'b0;
    rt_used = 1'b0;
    flush = 1'b0;
    slot_data = '0;
  endtask

  task automatic issue(input logic [RADDR-1:0] rd, input logic ld);
    idle();
    issue_valid = 1'b1;
    issue_we = 1'b1;
    issue_rd = rd;
    issue_load = ld;
    #1;
    step("iss");
  endtask

  initial begin
    for (int k = 0; k < DEPTH; k++) m[k] = '0;
    m_sc = 0;
    m_fc = 0;
    idle();
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;

    rs_addr = 5'd3; rs_used = 1'b1;
    #1;
    chk("rst_stall", stall, 0);
    chk("rst_a_en", fwd_a_en, 0);
    chk("rst_sc", stall_count, 0);
    step("rst");

    // ALU forward
    issue(5'd3, 1'b0);
    idle();
    rs_addr = 5'd3; rs_used = 1'b1;
    slot_data = pack(32'h1234, 32'h0, 32'h0);
    #1;
    chk("t1_a_en", fwd_a_en, 1);
    chk("t1_a", fwd_a, 32'h1234);
    chk("t1_stall", stall, 0);
    step("t1");

    // Load-use
    issue(5'd4, 1'b1);
    idle();
    issue_valid = 1'b1; rt_addr = 5'd4; rt_used = 1'b1;
    #1;
    chk("t2_stall1", stall, 1);
    step("t2a");
    slot_data = pack(32'h0, 32'hCAFE, 32'h0);
    #1;
    chk("t2_stall2", stall, 0);
    chk("t2_b_en", fwd_b_en, 1);
    chk("t2_b", fwd_b, 32'hCAFE);
    chk("t2_sc", stall_count, 1);
    step("t2b");

    // Youngest priority
    issue(5'd5, 1'b0);
    issue(5'd9, 1'b0);
    issue(5'd5, 1'b0);
    idle();
    rs_addr = 5'd5; rs_used = 1'b1;
    slot_data = pack(32'hAAAA, 32'h1111, 32'hBBBB);
    #1;
    chk("t3_a", fwd_a, 32'hAAAA);
    step("t3");

    // r0 and unused source
    issue(5'd0, 1'b0);
    idle();
    rs_addr = 5'd0; rs_used = 1'b1;
    slot_data = pack(32'h5555, 32'h0, 32'h0);
    #1;
    chk("t4_r0_en", fwd_a_en, 0);
    step("t4a");
    issue(5'd6, 1'b1);
    idle();
    issue_valid = 1'b1; rt_addr = 5'd6; rt_used = 1'b0;
    #1;
    chk("t4_unused_stall", stall, 0);
    step("t4b");

    // Flush over hazard
    issue(5'd7, 1'b1);
    idle();
    issue_valid = 1'b1; issue_we = 1'b1; issue_rd = 5'd8;
    rs_addr = 5'd7; rs_used = 1'b1; flush = 1'b1;
    #1;
    chk("t5_stall", stall, 0);
    step("t5a");
    idle();
    rs_addr = 5'd7; rs_used = 1'b1;
    rt_addr = 5'd8; rt_used = 1'b1;
    slot_data = pack(32'h0, 32'h7777, 32'h0);
    #1;
    chk("t5_fc", flush_count, 1);
    chk("t5_a_en", fwd_a_en, 1);
    chk("t5_a", fwd_a, 32'h7777);
    chk("t5_b_en", fwd_b_en, 0);
    step("t5b");

    // Reset mid-stream, also with simultaneous flush
    issue(5'd1, 1'b0);
    issue(5'd2, 1'b0);
    issue(5'd3, 1'b1);
    idle();
    rst = 1'b1; flush = 1'b1;
    #1;
    step("t6rst");
    idle();
    rs_addr = 5'd1; rs_used = 1'b1;
    rt_addr = 5'd3; rt_used = 1'b1;
    issue_valid = 1'b1;
    slot_data = pack(32'h1, 32'h2, 32'h3);
    #1;
    chk("t6_a_en", fwd_a_en, 0);
    chk("t6_b_en", fwd_b_en, 0);
    chk("t6_stall", stall, 0);
    chk("t6_sc", stall_count, 0);
    chk("t6_fc", flush_count, 0);
    step("t6");

    // Randomized traffic on a small register range to force overlap
    repeat (400) begin
      rst = ($urandom_range(0, 59) == 0);
      issue_valid = ($urandom_range(0, 3) != 0);
      issue_we = ($urandom_range(0, 4) != 0);
      issue_load = ($urandom_range(0, 2) == 0);
      issue_rd = 5'($urandom_range(0, 7));
      rs_addr = 5'($urandom_range(0, 7));
      rt_addr = 5'($urandom_range(0, 7));
      rs_used = ($urandom_range(0, 4) != 0);
      rt_used = ($urandom_range(0, 4) != 0);
      flush = ($urandom_range(0, 7) == 0);
      slot_data = pack($urandom, $urandom, $urandom);
      #1;
      step("rnd");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
